// File: rtl/aip_avalon_bridge_if.sv
// Avalon-MM slave port bundle for aip_avalon_bridge.
// master: the Nios-side bus master; slave: the bridge.
interface aip_avalon_bridge_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();
   logic [5:0]            avs_address;
   logic                  avs_write;
   logic                  avs_read;
   logic [DATA_WIDTH-1:0] avs_writedata;
   logic [DATA_WIDTH-1:0] avs_readdata;
   logic                  avs_waitrequest;

   modport master (
      output avs_address, avs_write, avs_read, avs_writedata,
      input  avs_readdata, avs_waitrequest
   );

   modport slave (
      input  avs_address, avs_write, avs_read, avs_writedata,
      output avs_readdata, avs_waitrequest
   );
endinterface

// File: rtl/aip_avalon_bridge.sv
// aip_avalon_bridge: Avalon-MM slave that sequences conf_dbus/data_in/write/read/start
// strobes for an AIP-style core, captures core read data, and exposes a command register
// (0x20, bit0 = start) and a status register (0x21, {busy, int_req, irq_pend}).
// Optional feature macro: AIP_BRIDGE_IRQ_LATCH_EN (sticky irq_pend, cleared by 0x21 write).
module aip_avalon_bridge #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned READ_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst_a,
   aip_avalon_bridge_if.slave    avs,
   output logic                  irq,
   output logic                  en_s,
   output logic [4:0]            conf_dbus,
   output logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  write,
   output logic                  read,
   output logic                  start,
   input  logic                  int_req
);

   localparam logic [5:0] AddrCmd  = 6'h20;
   localparam logic [5:0] AddrStat = 6'h21;
   // Cycle count (since the read strobe rose) at which data_out is sampled, and at which
   // CAPTURE hands over to DONE.
   localparam logic [2:0] CapCnt   = 3'(READ_LAT - 1);
   localparam logic [2:0] LastCnt  = 3'(READ_LAT);

   typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StCapture, StDone} state_e;

   state_e                state_q, state_d;
   logic [5:0]            addr_q, addr_d;
   logic                  is_wr_q, is_wr_d;
   logic                  wbit_q, wbit_d;
   logic [4:0]            conf_q, conf_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  en_q;
   logic                  int_req_q;
   logic                  busy_q, busy_d;

   logic                  wr_stb, rd_stb, st_stb, waitreq;
   logic                  is_aip;
   logic                  int_rise;
   logic                  irq_pend;
   logic [DATA_WIDTH-1:0] status;

   assign is_aip   = ~addr_q[5];
   assign int_rise = int_req & ~int_req_q;

   // Status word presented on 0x21 reads.
   always_comb begin
      status    = '0;
      status[2] = busy_q;
      status[1] = int_req;
      status[0] = irq_pend;
   end

   // Transfer sequencing: next state, strobes and latched request fields.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      is_wr_d = is_wr_q;
      wbit_d  = wbit_q;
      conf_d  = conf_q;
      din_d   = din_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      wr_stb  = 1'b0;
      rd_stb  = 1'b0;
      st_stb  = 1'b0;
      waitreq = 1'b1;
      unique case (state_q)
         StIdle: begin
            if (avs.avs_write) begin
               addr_d  = avs.avs_address;
               is_wr_d = 1'b1;
               wbit_d  = avs.avs_writedata[0];
               state_d = StSetup;
               if (!avs.avs_address[5]) begin
                  conf_d = avs.avs_address[4:0];
                  din_d  = avs.avs_writedata;
               end
            end else if (avs.avs_read) begin
               addr_d  = avs.avs_address;
               is_wr_d = 1'b0;
               wbit_d  = 1'b0;
               state_d = StSetup;
               if (!avs.avs_address[5]) begin
                  conf_d = avs.avs_address[4:0];
               end
            end
         end
         StSetup: begin
            if (is_aip || (is_wr_q && addr_q == AddrCmd)) begin
               state_d = StStrobe;
            end else begin
               state_d = StDone;
               if (!is_wr_q) begin
                  rdata_d = (addr_q == AddrStat) ? status : '0;
               end
            end
         end
         StStrobe: begin
            if (is_aip) begin
               if (is_wr_q) begin
                  wr_stb  = 1'b1;
                  state_d = StDone;
               end else begin
                  rd_stb  = 1'b1;
                  cnt_d   = 3'd1;
                  state_d = StCapture;
                  // With a one-cycle latency the core answers within the strobe cycle.
                  if (CapCnt == 3'd0) begin
                     rdata_d = data_out;
                  end
               end
            end else begin
               st_stb  = wbit_q;
               state_d = StDone;
            end
         end
         StCapture: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == CapCnt) begin
               rdata_d = data_out;
            end
            if (cnt_q == LastCnt) begin
               state_d = StDone;
            end
         end
         StDone: begin
            waitreq = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Core is busy from a start pulse until its next interrupt request edge.
   always_comb begin
      busy_d = busy_q;
      if (int_rise) busy_d = 1'b0;
      if (st_stb)   busy_d = 1'b1;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         is_wr_q   <= 1'b0;
         wbit_q    <= 1'b0;
         conf_q    <= '0;
         din_q     <= '0;
         rdata_q   <= '0;
         cnt_q     <= '0;
         en_q      <= 1'b0;
         int_req_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         is_wr_q   <= is_wr_d;
         wbit_q    <= wbit_d;
         conf_q    <= conf_d;
         din_q     <= din_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
         en_q      <= 1'b1;
         int_req_q <= int_req;
         busy_q    <= busy_d;
      end
   end

`ifdef AIP_BRIDGE_IRQ_LATCH_EN
   logic irq_pend_q, irq_pend_d;
   logic irq_clr;

   // Sticky pending flag; a new edge beats a simultaneous clear.
   always_comb begin
      irq_clr    = (state_q == StSetup) && is_wr_q && (addr_q == AddrStat) && wbit_q;
      irq_pend_d = int_rise | (irq_pend_q & ~irq_clr);
   end

   // Pending flag register.
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         irq_pend_q <= 1'b0;
      end else begin
         irq_pend_q <= irq_pend_d;
      end
   end

   assign irq_pend = irq_pend_q;
   assign irq      = irq_pend_q;
`else
   assign irq_pend = 1'b0;
   assign irq      = int_req_q;
`endif

   assign avs.avs_readdata    = rdata_q;
   assign avs.avs_waitrequest = waitreq;
   assign en_s                = en_q;
   assign conf_dbus           = conf_q;
   assign data_in             = din_q;
   assign write               = wr_stb;
   assign read                = rd_stb;
   assign start               = st_stb;

endmodule

// File: tb/tb_aip_avalon_bridge.sv
// Directed bench for aip_avalon_bridge: one instance with READ_LAT=1 fronting a small
// FIFO-style core model, one with READ_LAT=3 whose core drives valid data for one cycle only.
module tb_aip_avalon_bridge;

   logic clk = 1'b0;
   logic rst_a;
   always #5 clk = ~clk;

   aip_avalon_bridge_if #(.DATA_WIDTH(32)) if1 ();
   aip_avalon_bridge_if #(.DATA_WIDTH(32)) if3 ();

   logic        irq1, en1, wr1, rd1, st1, int_req1;
   logic [4:0]  conf1;
   logic [31:0] din1, dout1, src1;
   logic        irq3, en3, wr3, rd3, st3, int_req3;
   logic [4:0]  conf3;
   logic [31:0] din3, dout3;

   aip_avalon_bridge #(.DATA_WIDTH(32), .READ_LAT(1)) u_dut1 (
      .clk(clk), .rst_a(rst_a), .avs(if1.slave), .irq(irq1), .en_s(en1),
      .conf_dbus(conf1), .data_in(din1), .data_out(dout1), .write(wr1), .read(rd1),
      .start(st1), .int_req(int_req1)
   );

   aip_avalon_bridge #(.DATA_WIDTH(32), .READ_LAT(3)) u_dut3 (
      .clk(clk), .rst_a(rst_a), .avs(if3.slave), .irq(irq3), .en_s(en3),
      .conf_dbus(conf3), .data_in(din3), .data_out(dout3), .write(wr3), .read(rd3),
      .start(st3), .int_req(int_req3)
   );

   // Core model 1: 0x00 pushes, 0x02 pops, 0x1E status=1, 0x1F id=0x1001.
   logic [31:0] fifo [256];
   logic [7:0]  wr_ptr = 8'd0;
   logic [7:0]  rd_ptr = 8'd0;
   always_comb begin
      src1 = 32'h0;
      if (conf1 == 5'h1F)      src1 = 32'h0000_1001;
      else if (conf1 == 5'h1E) src1 = 32'h0000_0001;
      else if (conf1 == 5'h02) src1 = fifo[rd_ptr];
   end
   assign dout1 = rd1 ? src1 : 32'hBAD0_BAD0;
   always @(posedge clk) begin
      if (wr1 && conf1 == 5'h00) begin
         fifo[wr_ptr] <= din1;
         wr_ptr       <= wr_ptr + 8'd1;
      end
      if (rd1 && conf1 == 5'h02) rd_ptr <= rd_ptr + 8'd1;
   end

   // Core model 3: data valid only in the cycle before the edge 3 cycles after read rose.
   int rd_age3 = 0;
   always @(posedge clk) begin
      if (rd3)                             rd_age3 <= 1;
      else if (rd_age3 != 0 && rd_age3 < 15) rd_age3 <= rd_age3 + 1;
   end
   assign dout3 = (rd_age3 == 2) ? (32'h3300_0000 | {27'd0, conf3}) : 32'hBAD0_BAD0;

   // Strobe monitor for instance 1.
   int          n_wr = 0, n_rd = 0, n_st = 0, n_ovl = 0;
   logic [4:0]  lw_dbus = '0, lr_dbus = '0, prev_conf = '0;
   logic [31:0] lw_data = '0, prev_din = '0;
   bit          lw_stable = 1'b0, prev_any = 1'b0;
   always @(negedge clk) begin
      if (wr1) begin
         n_wr      <= n_wr + 1;
         lw_dbus   <= conf1;
         lw_data   <= din1;
         lw_stable <= (prev_conf == conf1) && (prev_din == din1);
      end
      if (rd1) begin
         n_rd    <= n_rd + 1;
         lr_dbus <= conf1;
      end
      if (st1) n_st <= n_st + 1;
      if ((32'(wr1) + 32'(rd1) + 32'(st1)) > 1) n_ovl <= n_ovl + 1;
      if ((wr1 | rd1 | st1) && prev_any)       n_ovl <= n_ovl + 1;
      prev_any  <= wr1 | rd1 | st1;
      prev_conf <= conf1;
      prev_din  <= din1;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One Avalon transfer; caller is at a negedge. cyc = negedges until waitrequest low.
   task automatic xfer(input bit sel, input logic [5:0] addr, input bit wr, input bit rd,
                       input logic [31:0] wd, output logic [31:0] rdat, output int cyc);
      logic w;
      if (sel) begin
         if3.avs_address = addr; if3.avs_write = wr; if3.avs_read = rd;
         if3.avs_writedata = wd;
      end else begin
         if1.avs_address = addr; if1.avs_write = wr; if1.avs_read = rd;
         if1.avs_writedata = wd;
      end
      cyc  = 0;
      rdat = 32'hFFFF_FFFF;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         w = sel ? if3.avs_waitrequest : if1.avs_waitrequest;
         if (!w) begin
            cyc  = i;
            rdat = sel ? if3.avs_readdata : if1.avs_readdata;
            break;
         end
      end
      if (sel) begin if3.avs_write = 1'b0; if3.avs_read = 1'b0; end
      else begin if1.avs_write = 1'b0; if1.avs_read = 1'b0; end
      if (cyc == 0) chk("xfer_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("wait_back_high", 32'(sel ? if3.avs_waitrequest : if1.avs_waitrequest), 32'd1);
   endtask

   logic [31:0] words [64];
   logic [31:0] rdat;
   int          cyc, b_wr, b_rd, b_st;
   bit          polled;

   initial begin
      rst_a = 1'b0;
      int_req1 = 1'b0; int_req3 = 1'b0;
      if1.avs_address = '0; if1.avs_write = 1'b0; if1.avs_read = 1'b0; if1.avs_writedata = '0;
      if3.avs_address = '0; if3.avs_write = 1'b0; if3.avs_read = 1'b0; if3.avs_writedata = '0;
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_readdata", if1.avs_readdata, 32'h0);
      chk("rst_waitreq", 32'(if1.avs_waitrequest), 32'd1);
      chk("rst_irq", 32'(irq1), 32'd0);
      chk("rst_en_s", 32'(en1), 32'd0);
      chk("rst_conf_dbus", 32'(conf1), 32'd0);
      chk("rst_data_in", din1, 32'h0);
      chk("rst_strobes", {29'd0, wr1, rd1, st1}, 32'd0);
      chk("rst_waitreq3", 32'(if3.avs_waitrequest), 32'd1);
      rst_a = 1'b1;
      @(negedge clk);
      chk("en_s_after_release", 32'(en1), 32'd1);

      // Read of core id register
      xfer(1'b0, 6'h1F, 1'b0, 1'b1, 32'h0, rdat, cyc);
      chk("rd1f_data", rdat, 32'h0000_1001);
      chk("rd1f_cycles", 32'(cyc), 32'd4);
      chk("rd1f_strobes", 32'(n_rd), 32'd1);
      chk("rd1f_dbus", 32'(lr_dbus), 32'h1F);

      // Write 0x01 <- 0, then 64 random words to 0x00
      xfer(1'b0, 6'h01, 1'b1, 1'b0, 32'h0, rdat, cyc);
      chk("wr01_cycles", 32'(cyc), 32'd3);
      chk("wr01_dbus", 32'(lw_dbus), 32'h01);
      for (int i = 0; i < 64; i++) begin
         words[i] = $urandom;
         xfer(1'b0, 6'h00, 1'b1, 1'b0, words[i], rdat, cyc);
         chk("wr00_cycles", 32'(cyc), 32'd3);
         chk("wr00_dbus", 32'(lw_dbus), 32'h00);
         chk("wr00_data", lw_data, words[i]);
         chk("wr00_setup_held", 32'(lw_stable), 32'd1);
      end
      chk("wr_pulse_count", 32'(n_wr), 32'd65);

      // Start command
      b_wr = n_wr; b_rd = n_rd; b_st = n_st;
      xfer(1'b0, 6'h20, 1'b1, 1'b0, 32'h1, rdat, cyc);
      chk("start1_cycles", 32'(cyc), 32'd3);
      chk("start1_pulse", 32'(n_st - b_st), 32'd1);
      chk("start1_no_rw", 32'((n_wr - b_wr) + (n_rd - b_rd)), 32'd0);
      xfer(1'b0, 6'h20, 1'b1, 1'b0, 32'h0, rdat, cyc);
      chk("start0_cycles", 32'(cyc), 32'd3);
      chk("start0_no_pulse", 32'(n_st - b_st), 32'd1);
      xfer(1'b0, 6'h21, 1'b0, 1'b1, 32'h0, rdat, cyc);
      chk("status_busy", rdat, 32'h4);
      chk("status_cycles", 32'(cyc), 32'd2);

      // Poll, then read back the 64 words through 0x02
      polled = 1'b0;
      for (int i = 0; i < 10 && !polled; i++) begin
         xfer(1'b0, 6'h1E, 1'b0, 1'b1, 32'h0, rdat, cyc);
         polled = rdat[0];
      end
      chk("poll_1e", 32'(polled), 32'd1);
      xfer(1'b0, 6'h03, 1'b1, 1'b0, 32'h0, rdat, cyc);
      for (int i = 0; i < 64; i++) begin
         xfer(1'b0, 6'h02, 1'b0, 1'b1, 32'h0, rdat, cyc);
         chk("rd02_data", rdat, words[i]);
         chk("rd02_cycles", 32'(cyc), 32'd4);
      end

      // Interrupt path
      chk("irq_idle", 32'(irq1), 32'd0);
      int_req1 = 1'b1;
      @(negedge clk);
      chk("irq_follow", 32'(irq1), 32'd1);
      int_req1 = 1'b0;
      @(negedge clk);
`ifdef AIP_BRIDGE_IRQ_LATCH_EN
      chk("irq_after_pulse", 32'(irq1), 32'd1);
`else
      chk("irq_after_pulse", 32'(irq1), 32'd0);
`endif
      int_req1 = 1'b1;
      xfer(1'b0, 6'h21, 1'b0, 1'b1, 32'h0, rdat, cyc);
`ifdef AIP_BRIDGE_IRQ_LATCH_EN
      chk("status_intreq", rdat, 32'h3);
`else
      chk("status_intreq", rdat, 32'h2);
`endif
      int_req1 = 1'b0;
      repeat (2) @(negedge clk);
      xfer(1'b0, 6'h21, 1'b0, 1'b1, 32'h0, rdat, cyc);
`ifdef AIP_BRIDGE_IRQ_LATCH_EN
      chk("status_pend", rdat, 32'h1);
`else
      chk("status_pend", rdat, 32'h0);
`endif
      xfer(1'b0, 6'h21, 1'b1, 1'b0, 32'h1, rdat, cyc);
      chk("irq_cleared", 32'(irq1), 32'd0);
      xfer(1'b0, 6'h21, 1'b0, 1'b1, 32'h0, rdat, cyc);
      chk("status_clear", rdat, 32'h0);

      // Unused and command-register reads, unused writes
      b_wr = n_wr; b_rd = n_rd; b_st = n_st;
      xfer(1'b0, 6'h25, 1'b1, 1'b0, 32'hFFFF_FFFF, rdat, cyc);
      chk("unused_wr_cycles", 32'(cyc), 32'd2);
      xfer(1'b0, 6'h3F, 1'b0, 1'b1, 32'h0, rdat, cyc);
      chk("unused_rd_data", rdat, 32'h0);
      xfer(1'b0, 6'h20, 1'b0, 1'b1, 32'h0, rdat, cyc);
      chk("cmd_rd_data", rdat, 32'h0);
      chk("unused_no_strobes", 32'((n_wr - b_wr) + (n_rd - b_rd) + (n_st - b_st)), 32'd0);

      // Write wins over a simultaneous read
      xfer(1'b0, 6'h00, 1'b1, 1'b1, 32'hA5A5_5A5A, rdat, cyc);
      chk("prio_cycles", 32'(cyc), 32'd3);
      chk("prio_write", 32'(n_wr - b_wr), 32'd1);
      chk("prio_no_read", 32'(n_rd - b_rd), 32'd0);
      chk("prio_data", lw_data, 32'hA5A5_5A5A);
      chk("no_overlap", 32'(n_ovl), 32'd0);

      // READ_LAT=3 instance
      xfer(1'b1, 6'h07, 1'b0, 1'b1, 32'h0, rdat, cyc);
      chk("lat3_data", rdat, 32'h3300_0007);
      chk("lat3_cycles", 32'(cyc), 32'd6);

      // Reset in the middle of a capture
      if3.avs_address = 6'h05; if3.avs_read = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_conf_before", 32'(conf3), 32'h05);
      chk("mid_wait_before", 32'(if3.avs_waitrequest), 32'd1);
      rst_a = 1'b0;
      if3.avs_read = 1'b0;
      #1;
      chk("mid_rst_readdata", if3.avs_readdata, 32'h0);
      chk("mid_rst_waitreq", 32'(if3.avs_waitrequest), 32'd1);
      chk("mid_rst_conf", 32'(conf3), 32'd0);
      chk("mid_rst_din", din3, 32'h0);
      chk("mid_rst_en_irq", {30'd0, en3, irq3}, 32'd0);
      chk("mid_rst_strobes", {29'd0, wr3, rd3, st3}, 32'd0);
      @(negedge clk);
      chk("mid_rst_no_done", 32'(if3.avs_waitrequest), 32'd1);
      @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      chk("mid_en_s_back", 32'(en3), 32'd1);
      xfer(1'b1, 6'h1F, 1'b0, 1'b1, 32'h0, rdat, cyc);
      chk("post_rst3_data", rdat, 32'h3300_001F);
      chk("post_rst3_cycles", 32'(cyc), 32'd6);
      xfer(1'b0, 6'h1F, 1'b0, 1'b1, 32'h0, rdat, cyc);
      chk("post_rst1_data", rdat, 32'h0000_1001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
